// File: rtl/debug_regdump_ctrl.sv
// debug_regdump_ctrl
//   Owns the register-bank debug read port. On i_dump_req it halts the
//   pipeline, waits SETTLE_CYCLES for it to freeze, then walks registers
//   0..NUM_REGS-1 and streams each 32-bit word LSB-first as bytes over a
//   valid/ready link. The halt is released when the walk completes.
//
//   Optional: define DEBUG_REGDUMP_CHECKSUM_EN to append one XOR checksum
//   byte (XOR of every transmitted payload byte) after the last register.
//
// Ports
//   i_clk, i_reset    clock / synchronous active-high reset
//   i_dump_req        start request, only honoured in IDLE
//   o_halt            pipeline halt (drives ID i_halt)
//   o_reg_read        debug read address to the register bank
//   i_reg_content     bank read data, combinational from o_reg_read
//   o_tx_data         byte to transmit
//   o_tx_valid        o_tx_data valid
//   i_tx_ready        sink accepts when valid && ready
//   o_busy            high in every state but IDLE
//   o_done            one-cycle pulse at dump completion
module debug_regdump_ctrl #(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dump_req,
    output logic                  o_halt,
    output logic [ADDR_WIDTH-1:0] o_reg_read,
    input  logic [31:0]           i_reg_content,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = ADDR_WIDTH'(NUM_REGS - 1);

`ifdef DEBUG_REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_LATCH, S_SEND, S_NEXT, S_CSUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_LATCH, S_SEND, S_NEXT, S_DONE
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     shift;
    logic            tx_fire;
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign tx_fire   = o_tx_valid && i_tx_ready;
    // Data comes straight off the shift register flops; in CSUM the
    // checksum is loaded into shift[7:0] so no output mux is needed.
    assign o_tx_data = shift[7:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_dump_req) state_nxt = S_HALT;
            S_HALT:  if (settle_cnt == SETTLE_LAST) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_SEND;
            S_SEND:  if (tx_fire && byte_idx == 2'd3) state_nxt = S_NEXT;
            S_NEXT: begin
                if (o_reg_read == ADDR_LAST) begin
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_LATCH;
                end
            end
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
            S_CSUM:  if (tx_fire) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            o_reg_read <= '0;
            o_halt     <= 1'b0;
            o_busy     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_done     <= 1'b0;
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state  <= state_nxt;
            // Status outputs are registered copies of the next state so they
            // line up exactly with the state they describe.
            o_halt <= (state_nxt != S_IDLE);
            o_busy <= (state_nxt != S_IDLE);
            o_done <= (state_nxt == S_DONE);
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
            o_tx_valid <= (state_nxt == S_SEND) || (state_nxt == S_CSUM);
`else
            o_tx_valid <= (state_nxt == S_SEND);
`endif
            case (state)
                S_IDLE: begin
                    settle_cnt <= '0;
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
                    csum       <= '0;
`endif
                    if (i_dump_req) o_reg_read <= '0;
                end
                S_HALT: settle_cnt <= settle_cnt + 1'b1;
                S_LATCH: begin
                    shift    <= i_reg_content;
                    byte_idx <= '0;
                end
                S_SEND: begin
                    if (tx_fire) begin
                        shift    <= {8'h00, shift[31:8]};
                        byte_idx <= byte_idx + 2'd1;
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
                        csum     <= csum ^ shift[7:0];
`endif
                    end
                end
                S_NEXT: begin
                    // Address stops at the last register; it never wraps.
                    if (o_reg_read != ADDR_LAST) begin
                        o_reg_read <= o_reg_read + 1'b1;
                    end
`ifdef DEBUG_REGDUMP_CHECKSUM_EN
                    else begin
                        shift <= {24'h0, csum};
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
